pwm_peripheral: RTL and testbench
=================================

Name: pwm_peripheral

Overview:
Consumes the five configuration registers written by the SPI register stage and drives 16 output pins. Each pin is forced low, forced high, or driven by a shared 8-bit PWM waveform, according to its enable bits. PWM period = 256 × CLK_DIV clk cycles; the duty cycle is double-buffered and updated only at period boundaries to avoid glitches. Sits directly downstream of the SPI register file; its outputs go to the chip's output pins.

Parameters:
CLK_DIV, 13, clk cycles per PWM counter step (≈3 kHz PWM at a 10 MHz clk); legal range ≥1.
NUM_CH, 16, number of output channels; fixed at 16, matching the 2×8-bit enable registers.

Ports:
clk  input  1  system clock, all logic on its rising edge
rst_n  input  1  asynchronous active-low reset
en_reg_out_7_0  input  8  output enable, channels 7..0
en_reg_out_15_8  input  8  output enable, channels 15..8
en_reg_pwm_7_0  input  8  PWM mode select, channels 7..0
en_reg_pwm_15_8  input  8  PWM mode select, channels 15..8
pwm_duty_cycle  input  8  requested duty, 0x00 = 0%, 0xFF = 100%
out  output  16  registered channel outputs

Behaviour:
- Reset: the one clock is clk; reset is rst_n, asynchronous assert, active-low. Reset clears out=0, prescaler=0, pwm_cnt=0, duty_shadow=0.
- Inputs are quasi-static register outputs in the clk domain. No synchronisers are required.
- Prescaler: counts 0..CLK_DIV-1 and wraps. tick=1 in the cycle where prescaler==CLK_DIV-1. With CLK_DIV=1, tick is constantly 1.
- pwm_cnt: 8-bit. Increments on tick; wraps 255→0 naturally.
- Period boundary: tick && pwm_cnt==255. In that cycle, duty_shadow ← pwm_duty_cycle, so the new value applies from pwm_cnt==0.
- A duty change mid-period has no effect until the next boundary.
- First period after reset uses duty_shadow=0, so PWM is low for the first full period.
- pwm_sig (combinational):
  - duty_shadow==0xFF → 1 (true 100%).
  - Otherwise → (pwm_cnt < duty_shadow).
  - 0x00 → always 0.
  - High time per period = duty_shadow × CLK_DIV cycles.
- Channel i select (registered; next-state of out[i]):
  - en_out[i]==0 → 0. The enable has priority over the PWM bit.
  - en_out[i]==1 && en_pwm[i]==0 → 1.
  - en_out[i]==1 && en_pwm[i]==1 → pwm_sig.
  - en_out = {en_reg_out_15_8, en_reg_out_7_0}; en_pwm likewise.
- Latency: an enable-register change appears on out exactly 1 clk later. A pwm_cnt/shadow change also appears 1 clk later.
- All PWM channels share one waveform and are phase-aligned.
- Reset mid-period: out drops to 0 immediately (asynchronously). After release, counting restarts from 0 and the shadow holds 0 until the first boundary.
- Enable toggled mid-period: takes effect on the next clk with no boundary wait. Only the duty is buffered.

Decomposition:
- Package pwm_pkg:
  - PWM_CNT_W=8
  - NUM_CH=16
  - DUTY_FULL=8'hFF
  - DEFAULT_CLK_DIV=13
- Sub-module pwm_timebase (prescaler, pwm_cnt, duty_shadow, pwm_sig output), parameterised by CLK_DIV.
- The top level instantiates it and holds the 16-channel mux and output register.

Test Plan:
1. Reset, then en_out=0xFFFF, en_pwm=0x0000 → out=0xFFFF exactly 1 clk after the write. Then en_out=0x00F0 → out=0x00F0 one clk later.
2. en_out=0x0001, en_pwm=0x0001, duty=0x80, CLK_DIV=13 → after the first boundary, out[0] period=3328 clk and high time=1664 clk (50%), measured over 3 periods.
3. duty=0x00 → out[0] stays low for all periods. duty=0xFF → out[0] stays high continuously after the next boundary, with no 1-cycle low pulse at wrap.
4. Duty changed 0x40→0xC0 at pwm_cnt≈100 → the current period keeps high time 64×13 clk. The next period has high time 192×13=2496 clk.
5. PWM running, en_out[0] cleared mid-high → out[0]=0 next clk while the other channels keep toggling. en_pwm set with en_out clear → out stays 0.
6. rst_n pulsed low mid-period → out=0 immediately, without waiting for a clk edge. After release, the first full period (3328 clk) is low, then the programmed duty resumes.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths and constants for the PWM peripheral
package pwm_pkg;
  localparam int PWM_CNT_W = 8;
  localparam int NUM_CH = 16;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
  localparam int DEFAULT_CLK_DIV = 13;
endpackage

// File: rtl/pwm_peripheral_if.sv
// pwm_peripheral_if: register-file configuration in, channel pins out
interface pwm_peripheral_if;
  import pwm_pkg::*;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [PWM_CNT_W-1:0] pwm_duty_cycle;
  logic [NUM_CH-1:0] out;
  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out
  );
  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out
  );
endinterface

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler, 8-bit period counter and double-buffered duty compare
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PWM_CNT_W-1:0] duty_i,
  output logic                 pwm_sig_o
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  logic [PW-1:0] pre_q, pre_d;
  logic [PWM_CNT_W-1:0] cnt_q, cnt_d, shadow_q, shadow_d;
  logic tick;
  // shadow reloads on the last step of a period so the new duty starts at cnt 0
  always_comb begin
    tick = pre_q == PRE_MAX;
    pre_d = tick ? '0 : pre_q + 1'b1;
    cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
    shadow_d = (tick && cnt_q == '1) ? duty_i : shadow_q;
    pwm_sig_o = (shadow_q == DUTY_FULL) || (cnt_q < shadow_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
      shadow_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      shadow_q <= shadow_d;
    end
  end
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 registered output pins, each off, on, or the shared PWM waveform
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input logic             clk,
  input logic             rst_n,
  pwm_peripheral_if.slave bus
);
  logic pwm_sig;
  logic [NUM_CH-1:0] en_out, en_pwm, out_d, out_q;
  pwm_timebase #(.CLK_DIV(CLK_DIV)) u_tb (
    .clk      (clk),
    .rst_n    (rst_n),
    .duty_i   (bus.pwm_duty_cycle),
    .pwm_sig_o(pwm_sig)
  );
  // output enable dominates; PWM mode only chooses between steady-high and waveform
  always_comb begin
    en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    out_d = en_out & (~en_pwm | {NUM_CH{pwm_sig}});
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else out_q <= out_d;
  end
  assign bus.out = out_q;
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: scoreboarded cycle model plus directed period/duty measurements
module tb_pwm_peripheral;
  import pwm_pkg::*;
  localparam int CLK_DIV = DEFAULT_CLK_DIV;
  localparam int PER = 256 * CLK_DIV;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;
  logic [15:0] sb[$];
  int m_pre = 0;
  logic [7:0] m_cnt = '0;
  logic [7:0] m_sh = '0;
  logic m_sig;
  logic [15:0] m_eo, m_ep, m_exp;

  pwm_peripheral_if bus();
  pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: predicts out after each edge and queues it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre <= 0;
      m_cnt <= '0;
      m_sh <= '0;
      sb.delete();
    end else begin
      m_sig = (m_sh == 8'hFF) ? 1'b1 : (m_cnt < m_sh);
      m_eo = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
      m_ep = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
      for (int i = 0; i < 16; i++)
        m_exp[i] = !m_eo[i] ? 1'b0 : (!m_ep[i] ? 1'b1 : m_sig);
      sb.push_back(m_exp);
      if (m_pre == CLK_DIV - 1) begin
        m_pre <= 0;
        m_cnt <= m_cnt + 8'd1;
        if (m_cnt == 8'hFF) m_sh <= bus.pwm_duty_cycle;
      end else m_pre <= m_pre + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) check("rst", bus.out, 0);
    else if (sb.size() > 0) check("sb", bus.out, sb.pop_front());
  end

  task automatic set_en(input logic [15:0] o, input logic [15:0] p);
    bus.en_reg_out_7_0 = o[7:0];
    bus.en_reg_out_15_8 = o[15:8];
    bus.en_reg_pwm_7_0 = p[7:0];
    bus.en_reg_pwm_15_8 = p[15:8];
  endtask

  task automatic wait_level(input int ch, input logic v, input int bound, output int n);
    n = 0;
    while (bus.out[ch] !== v && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (bus.out[ch] !== v) check("timeout", bus.out[ch], v);
  endtask

  task automatic count_hi(input int ch, input int len, output int n);
    n = 0;
    repeat (len) begin
      @(negedge clk);
      n += int'(bus.out[ch]);
    end
  endtask

  initial begin
    int n, hi, lo;
    bus.pwm_duty_cycle = 8'h00;
    set_en(16'h0000, 16'h0000);
    #1 rst_n = 1'b0;
    #1 check("rst_async", bus.out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_en(16'hFFFF, 16'h0000);
    check("t1_hold", bus.out, 16'h0000);
    @(negedge clk);
    check("t1_ffff", bus.out, 16'hFFFF);
    set_en(16'h00F0, 16'h0000);
    @(negedge clk);
    check("t1_f0", bus.out, 16'h00F0);
    bus.pwm_duty_cycle = 8'h80;
    set_en(16'h0001, 16'h0001);
    wait_level(0, 1'b1, 2 * PER, n);
    check("t2_first_low", n, PER - 2);
    for (int k = 0; k < 3; k++) begin
      wait_level(0, 1'b0, PER, hi);
      check("t2_hi", hi, 128 * CLK_DIV);
      wait_level(0, 1'b1, PER, lo);
      check("t2_per", hi + lo, PER);
    end
    bus.pwm_duty_cycle = 8'h40;
    wait_level(0, 1'b0, PER, hi);
    check("t4_hi80", hi, 128 * CLK_DIV);
    wait_level(0, 1'b1, PER, lo);
    wait_level(0, 1'b0, PER, hi);
    check("t4_hi40", hi, 64 * CLK_DIV);
    repeat (36 * CLK_DIV) @(negedge clk);
    bus.pwm_duty_cycle = 8'hC0;
    wait_level(0, 1'b1, PER, lo);
    check("t4_lo40", lo, PER - 100 * CLK_DIV);
    wait_level(0, 1'b0, PER, hi);
    check("t4_hiC0", hi, 192 * CLK_DIV);
    bus.pwm_duty_cycle = 8'h00;
    repeat (64 * CLK_DIV + 8) @(negedge clk);
    count_hi(0, 2 * PER, n);
    check("t3_zero", n, 0);
    bus.pwm_duty_cycle = 8'hFF;
    repeat (PER + 8) @(negedge clk);
    count_hi(0, 2 * PER, n);
    check("t3_full", n, 2 * PER);
    bus.pwm_duty_cycle = 8'h80;
    set_en(16'h0003, 16'h0003);
    repeat (PER + 8) @(negedge clk);
    wait_level(0, 1'b1, PER, n);
    repeat (300) @(negedge clk);
    check("t5_pre", bus.out[1:0], 2'b11);
    set_en(16'h0002, 16'h0003);
    @(negedge clk);
    check("t5_off0", bus.out[0], 1'b0);
    check("t5_on1", bus.out[1], 1'b1);
    count_hi(1, PER, n);
    check("t5_ch1", n, 128 * CLK_DIV);
    count_hi(0, PER, n);
    check("t5_ch0", n, 0);
    set_en(16'h0006, 16'h0002);
    repeat (2) @(negedge clk);
    check("t6_pre", bus.out[2], 1'b1);
    #2 rst_n = 1'b0;
    #1 check("t6_async", bus.out, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_hi(1, PER, n);
    check("t6_low", n, 0);
    wait_level(1, 1'b1, 8, n);
    check("t6_first", n, 1);
    wait_level(1, 1'b0, PER, hi);
    check("t6_hi", hi, 128 * CLK_DIV);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
